// File: rtl/mdu_pkg.sv
// Shared encodings, latencies and result payload for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 4;

  // md_op encodings, also used by decode and the hazard unit
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath working on the latched operands.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output md_result_t      res_o,
  output logic            div_by_zero_o
);

  logic signed [2*XLEN-1:0] sa_wide;
  logic signed [2*XLEN-1:0] sb_wide;
  logic signed [2*XLEN-1:0] prod_s;
  logic        [2*XLEN-1:0] prod_u;
  logic signed [XLEN-1:0]   sa;
  logic signed [XLEN-1:0]   sb_safe;
  logic        [XLEN-1:0]   ub_safe;
  logic                     b_zero;
  logic                     div_ovf;

  // Products and quotients; divisor forced to 1 on zero so no X/trap propagates
  always_comb begin
    b_zero   = (b_i == '0);
    div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    sa_wide  = {{XLEN{a_i[XLEN-1]}}, a_i};
    sb_wide  = {{XLEN{b_i[XLEN-1]}}, b_i};
    prod_s   = sa_wide * sb_wide;
    prod_u   = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};
    sa       = a_i;
    sb_safe  = b_zero ? XLEN'(1) : b_i;
    ub_safe  = b_zero ? XLEN'(1) : b_i;
    res_o    = '0;
    div_by_zero_o = 1'b0;
    case (op_i)
      MD_MULT:  res_o = prod_s;
      MD_MULTU: res_o = prod_u;
      MD_DIV: begin
        div_by_zero_o = b_zero;
        if (div_ovf) begin
          res_o.lo = 32'h8000_0000;
          res_o.hi = '0;
        end else begin
          res_o.lo = sa / sb_safe;
          res_o.hi = sa % sb_safe;
        end
      end
      MD_DIVU: begin
        div_by_zero_o = b_zero;
        res_o.lo = a_i / ub_safe;
        res_o.hi = a_i % ub_safe;
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO registers, multi-cycle MULT/DIV, single-cycle MTHI/MTLO.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            busy_q, busy_d;
  md_result_t      res;
  logic            div_by_zero;

  mdu_arith u_arith (
    .op_i          (op_q),
    .a_i           (a_q),
    .b_i           (b_q),
    .res_o         (res),
    .div_by_zero_o (div_by_zero)
  );

  // State, operand and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: accept in IDLE, count down in RUN, write HI/LO on the last count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              op_d    = md_op;
              a_d     = A;
              b_d     = B;
              cnt_d   = md_op[1] ? CNTW'(DIV_CYCLES) : CNTW'(MULT_CYCLES);
              state_d = S_RUN;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = S_IDLE;
          if (!div_by_zero) begin
            hi_d = res.hi;
            lo_d = res.lo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
